// File: rtl/line_mem_if.sv
// line_mem_if: line-granular fill/eviction bus between one cache and its memory responder
//   master (cache): drives readMemAddr/readMemReq and writeMemAddr/writeMemLine/writeMemReq
//   slave (memory): drives readMemData/readMemLineValid, writeMemAck and busy
interface line_mem_if #(
  parameter int ARCH_BITS = 32,
  parameter int MEMORY_LINE_BITS = 128
);
  logic [ARCH_BITS-1:0] readMemAddr;
  logic readMemReq;
  logic [MEMORY_LINE_BITS-1:0] readMemData;
  logic readMemLineValid;
  logic [ARCH_BITS-1:0] writeMemAddr;
  logic [MEMORY_LINE_BITS-1:0] writeMemLine;
  logic writeMemReq;
  logic writeMemAck;
  logic busy;
  modport master(
    output readMemAddr, readMemReq, writeMemAddr, writeMemLine, writeMemReq,
    input readMemData, readMemLineValid, writeMemAck, busy
  );
  modport slave(
    input readMemAddr, readMemReq, writeMemAddr, writeMemLine, writeMemReq,
    output readMemData, readMemLineValid, writeMemAck, busy
  );
endinterface

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line memory serving one cache's fills and evictions
//   clk, rst (async, active high); bus: line_mem_if slave side
//   a request accepted in IDLE at edge E pulses readMemLineValid or writeMemAck at edge E+LATENCY
module line_mem_responder #(
  parameter int ARCH_BITS = 32,
  parameter int MEMORY_LINE_BITS = 128,
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS = 8,
  parameter int LATENCY = 5
) (
  input logic clk,
  input logic rst,
  line_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE_WAIT, READ_WAIT} state_t;
  state_t state, state_n;
  logic [7:0] count;
  logic [INDEX_BITS-1:0] idx, widx, ridx;
  logic [MEMORY_LINE_BITS-1:0] wline, rdata;
  logic [MEMORY_LINE_BITS-1:0] mem [2**INDEX_BITS];
  logic valid, ack, fire, unused_bits;
  assign widx = bus.writeMemAddr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign ridx = bus.readMemAddr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign unused_bits = ^{bus.writeMemAddr, bus.readMemAddr};
  assign fire = state != IDLE && count == '0;
  // write wins in IDLE: during an eviction the cache raises both requests
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = bus.writeMemReq ? WRITE_WAIT : bus.readMemReq ? READ_WAIT : IDLE;
    else if (count == '0)
      state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      idx <= '0;
      wline <= '0;
      rdata <= '0;
      valid <= 1'b0;
      ack <= 1'b0;
    end else begin
      state <= state_n;
      valid <= fire && state == READ_WAIT;
      ack <= fire && state == WRITE_WAIT;
      if (state == IDLE && (bus.writeMemReq || bus.readMemReq)) begin
        idx <= bus.writeMemReq ? widx : ridx;
        count <= 8'(LATENCY - 1);
      end else if (state != IDLE)
        count <= count - 8'd1;
      if (state == IDLE && bus.writeMemReq)
        wline <= bus.writeMemLine;
      if (fire && state == READ_WAIT)
        rdata <= mem[idx];
    end
  end
  // array is not reset; an async reset drops state to IDLE so an aborted write never lands
  always_ff @(posedge clk)
    if (fire && state == WRITE_WAIT)
      mem[idx] <= wline;
  assign bus.readMemData = rdata;
  assign bus.readMemLineValid = valid;
  assign bus.writeMemAck = ack;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: table-driven, directed and random checks of line_mem_responder
module tb_line_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  line_mem_if m();
  line_mem_if q();
  line_mem_responder #(.LATENCY(5)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  line_mem_responder #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(q.slave));
  int total = 0;
  int bad = 0;
  logic [127:0] model [256];
  typedef struct {
    bit w, r, drop;
    logic [31:0] wa, ra;
    logic [127:0] wl;
    int ka, kv;
    logic [127:0] d;
  } vec_t;
  vec_t tbl[$];
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // drives one transaction from a negedge; k counts edges from acceptance (k=0)
  task automatic run(input bit w, input bit r, input bit drop, input logic [31:0] wa,
                     input logic [31:0] ra, input logic [127:0] wl,
                     output int ka, output int kv, output logic [127:0] d);
    bit wp, rp;
    ka = -1; kv = -1; d = '0; wp = w; rp = r;
    m.writeMemReq = w; m.readMemReq = r;
    m.writeMemAddr = wa; m.readMemAddr = ra; m.writeMemLine = wl;
    for (int k = 0; k < 40 && (wp || rp); k++) begin
      @(posedge clk); @(negedge clk);
      check("overlap", 128'(m.writeMemAck & m.readMemLineValid), '0);
      if (m.writeMemAck) begin
        if (ka < 0) ka = k;
        wp = 0; m.writeMemReq = 1'b0;
      end
      if (m.readMemLineValid) begin
        if (kv < 0) kv = k;
        d = m.readMemData; rp = 0; m.readMemReq = 1'b0;
      end
      if (k == 0) begin
        if (w) begin
          m.writeMemAddr = $urandom;
          m.writeMemLine = {$urandom, $urandom, $urandom, $urandom};
        end else m.readMemAddr = $urandom;
        if (drop) begin m.writeMemReq = 1'b0; m.readMemReq = 1'b0; end
      end
    end
    @(posedge clk); @(negedge clk);
    check("extra_pulse", 128'({m.writeMemAck, m.readMemLineValid}), '0);
    check("busy_after", 128'(m.busy), '0);
  endtask
  task automatic apply(input vec_t v, input string tag);
    int ka, kv;
    logic [127:0] d;
    run(v.w, v.r, v.drop, v.wa, v.ra, v.wl, ka, kv, d);
    check({tag, "_ack_cycle"}, 128'(ka), 128'(v.ka));
    check({tag, "_valid_cycle"}, 128'(kv), 128'(v.kv));
    if (v.kv >= 0) check({tag, "_data"}, d, v.d);
  endtask
  initial begin
    logic [127:0] la, l1, l2, l3, p, z;
    int ks[$];
    bit prev, v;
    la = {32{4'hA}};
    l1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    l2 = 128'hC0DE_0200_C0DE_0200_C0DE_0200_C0DE_0200;
    l3 = 128'h5151_0050_A1A5_0050_5151_0050_A1A5_0050;
    p  = 128'h3030_3030_DEAD_BEEF_3030_3030_CAFE_F00D;
    z  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0050, 32'h0, la, 5, -1, '0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0050, '0, -1, 5, la});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0120, 32'h0, l1, 5, -1, '0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0128, '0, -1, 5, l1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_1200, l2, 5, 11, l2});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0001_0050, 32'h0, l3, 5, -1, '0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0050, '0, -1, 5, l3});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, p, 5, -1, '0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0124, '0, -1, 5, l1});
    rst = 1'b1;
    m.readMemReq = 1'b0; m.writeMemReq = 1'b0;
    m.readMemAddr = '0; m.writeMemAddr = '0; m.writeMemLine = '0;
    q.readMemReq = 1'b0; q.writeMemReq = 1'b0;
    q.readMemAddr = '0; q.writeMemAddr = '0; q.writeMemLine = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", 128'(m.readMemLineValid), '0);
    check("reset_ack", 128'(m.writeMemAck), '0);
    check("reset_data", m.readMemData, '0);
    check("reset_busy", 128'(m.busy), '0);
    rst = 1'b0;
    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // reset in the middle of an eviction to line 0x30
    m.writeMemReq = 1'b1; m.writeMemAddr = 32'h0000_0300; m.writeMemLine = z;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    m.writeMemReq = 1'b0; m.readMemReq = 1'b1; m.readMemAddr = 32'h0000_0300;
    #1;
    check("midrst_ack", 128'(m.writeMemAck), '0);
    check("midrst_valid", 128'(m.readMemLineValid), '0);
    check("midrst_data", m.readMemData, '0);
    check("midrst_busy", 128'(m.busy), '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_hold", 128'({m.writeMemAck, m.readMemLineValid, m.busy}), '0);
    end
    rst = 1'b0;
    apply('{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0300, '0, -1, 5, p}, "after_rst");
    // random traffic against a line-array model
    for (int i = 0; i < 16; i++) begin
      vec_t pv;
      model[i] = {$urandom, $urandom, $urandom, $urandom};
      pv = '{1'b1, 1'b0, 1'b0, ($urandom & 32'hFFFF_F000) | 32'(i << 4), 32'h0, model[i], 5, -1, '0};
      apply(pv, "preload");
    end
    for (int i = 0; i < 40; i++) begin
      vec_t rv;
      int op, iw, ir;
      op = $urandom_range(0, 2);
      iw = $urandom_range(0, 15);
      ir = $urandom_range(0, 15);
      rv.w = op != 1; rv.r = op != 0; rv.drop = 1'b0;
      rv.wa = ($urandom & 32'hFFFF_F000) | 32'(iw << 4) | 32'($urandom_range(0, 15));
      rv.ra = ($urandom & 32'hFFFF_F000) | 32'(ir << 4) | 32'($urandom_range(0, 15));
      rv.wl = {$urandom, $urandom, $urandom, $urandom};
      if (rv.w) model[iw] = rv.wl;
      rv.ka = rv.w ? 5 : -1;
      rv.kv = !rv.r ? -1 : rv.w ? 11 : 5;
      rv.d = model[ir];
      apply(rv, $sformatf("rnd%0d", i));
    end
    // LATENCY=1 instance: back-to-back fills
    q.readMemReq = 1'b1; q.readMemAddr = 32'h10;
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      v = q.readMemLineValid;
      check("l1_consecutive", 128'(v & prev), '0);
      if (v) begin
        ks.push_back(k);
        q.readMemAddr = ks.size() == 1 ? 32'h20 : 32'h30;
        if (ks.size() == 3) q.readMemReq = 1'b0;
      end
      prev = v;
    end
    check("l1_count", 128'(ks.size()), 128'(3));
    if (ks.size() == 3) begin
      check("l1_pulse0", 128'(ks[0]), 128'(1));
      check("l1_pulse1", 128'(ks[1]), 128'(3));
      check("l1_pulse2", 128'(ks[2]), 128'(5));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
